// File: rtl/approx_seq_mult_if.sv
// rtl/approx_seq_mult_if.sv - start/busy/done handshake bundle for approx_seq_mult
interface approx_seq_mult_if #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16
);
    logic                       start;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
    logic                       approx_en;
    logic                       busy;
    logic                       done;
    logic [A_WIDTH+B_WIDTH-1:0] m;

    // Requester side: issues operands, watches status and result
    modport master (
        output start, a, b, approx_en,
        input  busy, done, m
    );

    // Multiplier side
    modport slave (
        input  start, a, b, approx_en,
        output busy, done, m
    );
endinterface

// File: rtl/approx_seq_mult.sv
// rtl/approx_seq_mult.sv - radix-4 iterative multiplier with optional LSB-column truncation
module approx_seq_mult #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int TRUNC   = 8
) (
    input  logic               clk,
    input  logic               rst,
    approx_seq_mult_if.slave   bus
);
    localparam int P  = A_WIDTH + B_WIDTH;
    localparam int N  = B_WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [A_WIDTH-1:0] a_q, a_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               approx_q, approx_d;
    logic [P-1:0]       acc_q, acc_d;
    logic [IW-1:0]      i_q, i_d;
    logic [P-1:0]       m_q, m_d;

    logic [A_WIDTH+1:0] pp;
    logic [P-1:0]       term_raw;
    logic [P-1:0]       term;
    logic [P-1:0]       keep_mask;

    // Columns at or above TRUNC survive truncation; computed once from the parameter
    always_comb begin
        keep_mask = '0;
        for (int k = 0; k < P; k++) begin
            keep_mask[k] = (k >= TRUNC);
        end
    end

    // Partial product of the current digit; b_q is shifted down so the digit is always its LSBs.
    // The mask applies to absolute product columns, so it is applied after the 2i shift.
    always_comb begin
        pp       = a_q * b_q[1:0];
        term_raw = P'(pp) << {i_q, 1'b0};
        term     = approx_q ? (term_raw & keep_mask) : term_raw;
    end

    // Next-state logic for accept, digit accumulation and completion
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        approx_d = approx_q;
        acc_d    = acc_q;
        i_d      = i_q;
        m_d      = m_q;
        case (state_q)
            ST_RUN: begin
                acc_d = acc_q + term;
                b_d   = b_q >> 2;
                i_d   = i_q + 1'b1;
                if (i_q == IW'(N - 1)) begin
                    m_d     = acc_q + term;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    approx_d = bus.approx_en;
                    acc_d    = '0;
                    i_d      = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers; reset discards any in-flight operation and clears the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            i_q      <= '0;
            m_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            m_q      <= m_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.m    = m_q;
endmodule

// File: tb/tb_approx_seq_mult.sv
// tb/tb_approx_seq_mult.sv - directed self-checking bench for approx_seq_mult
module tb_approx_seq_mult;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    approx_seq_mult_if #(.A_WIDTH(16), .B_WIDTH(16)) bus ();
    approx_seq_mult_if #(.A_WIDTH(8),  .B_WIDTH(4))  bus2 ();

    approx_seq_mult #(.A_WIDTH(16), .B_WIDTH(16), .TRUNC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    approx_seq_mult #(.A_WIDTH(8), .B_WIDTH(4), .TRUNC(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one multiply on the 16x16 instance and wait (bounded) for done
    task automatic run_mul(input logic [15:0] ta, input logic [15:0] tbv, input logic tap,
                           output logic [31:0] got, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tbv; bus.approx_en = tap;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        got = bus.m;
    endtask

    task automatic run_mul2(input logic [7:0] ta, input logic [3:0] tbv, input logic tap,
                            output logic [11:0] got, output int lat);
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = ta; bus2.b = tbv; bus2.approx_en = tap;
        @(negedge clk);
        bus2.start = 1'b0;
        lat = 0;
        while (bus2.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = bus2.m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.approx_en = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.approx_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.m !== 32'h0) begin fails++; $display("FAIL reset_m got %h exp 0", bus.m); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy %b done %b exp 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_exact_max();
        logic [31:0] got; int lat; int bc;
        run_mul(16'hFFFF, 16'hFFFF, 1'b0, got, lat, bc);
        checks++; if (lat !== 8) begin fails++; $display("FAIL max_latency got %0d exp 8", lat); end
        checks++; if (bc !== 8) begin fails++; $display("FAIL max_busy_cycles got %0d exp 8", bc); end
        checks++; if (got !== 32'hFFFE0001) begin fails++; $display("FAIL max_exact got %h exp fffe0001", got); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL done_pulse_width done %b busy %b exp 0 0", bus.done, bus.busy); end
        checks++; if (bus.m !== 32'hFFFE0001) begin fails++; $display("FAIL m_hold got %h exp fffe0001", bus.m); end
    endtask

    task automatic test_truncated();
        logic [31:0] got; int lat; int bc;
        run_mul(16'h00FF, 16'h0003, 1'b1, got, lat, bc);
        checks++; if (got !== 32'h00000200) begin fails++; $display("FAIL trunc_small got %h exp 00000200", got); end
        run_mul(16'h00FF, 16'h0003, 1'b0, got, lat, bc);
        checks++; if (got !== 32'h000002FD) begin fails++; $display("FAIL exact_small got %h exp 000002fd", got); end
        // Lost columns: 0xFD+0xF4+0xD0+0x40 = 0x301 below the exact 0xFFFE0001
        run_mul(16'hFFFF, 16'hFFFF, 1'b1, got, lat, bc);
        checks++; if (got !== 32'hFFFDFD00) begin fails++; $display("FAIL trunc_max got %h exp fffdfd00", got); end
    endtask

    task automatic test_zero_identity();
        logic [31:0] got; int lat; int bc;
        run_mul(16'h1234, 16'h0000, 1'b0, got, lat, bc);
        checks++; if (got !== 32'h0) begin fails++; $display("FAIL b_zero got %h exp 0", got); end
        run_mul(16'h1234, 16'h0001, 1'b0, got, lat, bc);
        checks++; if (got !== 32'h00001234) begin fails++; $display("FAIL b_one got %h exp 00001234", got); end
        run_mul(16'h0000, 16'hFFFF, 1'b0, got, lat, bc);
        checks++; if (got !== 32'h0) begin fails++; $display("FAIL a_zero got %h exp 0", got); end
    endtask

    task automatic test_handshake();
        int lat; int gap;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd5; bus.approx_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd7;
        @(negedge clk); lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 8) begin fails++; $display("FAIL hs_latency got %0d exp 8", lat); end
        checks++; if (bus.m !== 32'd15) begin fails++; $display("FAIL hs_ignore_start got %0d exp 15", bus.m); end
        bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd9;
        @(negedge clk);
        bus.start = 1'b0; gap = 1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL hs_reaccept done %b busy %b exp 0 1", bus.done, bus.busy); end
        checks++; if (bus.m !== 32'd15) begin fails++; $display("FAIL hs_m_stable got %0d exp 15", bus.m); end
        while (bus.done !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
        checks++; if (gap !== 9) begin fails++; $display("FAIL hs_done_gap got %0d exp 9", gap); end
        checks++; if (bus.m !== 32'd18) begin fails++; $display("FAIL hs_second got %0d exp 18", bus.m); end
    endtask

    task automatic test_back_to_back();
        int lat; int gap; int low;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd5; bus.b = 16'd6; bus.approx_en = 1'b0;
        @(negedge clk); lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        gap = 0; low = 0;
        do begin
            if (bus.busy === 1'b0) low++;
            @(negedge clk); gap++;
        end while (bus.done !== 1'b1 && gap < 40);
        bus.start = 1'b0;
        checks++; if (gap !== 9) begin fails++; $display("FAIL b2b_period got %0d exp 9", gap); end
        checks++; if (low !== 1) begin fails++; $display("FAIL b2b_busy_low got %0d exp 1", low); end
        checks++; if (bus.m !== 32'd30) begin fails++; $display("FAIL b2b_m got %0d exp 30", bus.m); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] got; int lat; int bc; int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.approx_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL async_rst_status busy %b done %b exp 0 0", bus.busy, bus.done); end
        checks++; if (bus.m !== 32'h0) begin fails++; $display("FAIL async_rst_m got %h exp 0", bus.m); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) dones++; end
        checks++; if (dones !== 0) begin fails++; $display("FAIL rst_no_done got %0d active cycles exp 0", dones); end
        run_mul(16'd10, 16'd10, 1'b0, got, lat, bc);
        checks++; if (got !== 32'd100) begin fails++; $display("FAIL after_rst got %0d exp 100", got); end
    endtask

    task automatic test_param_sweep();
        logic [11:0] got; int lat;
        logic [7:0]  ra;
        logic [3:0]  rb;
        logic [11:0] exp_m;
        for (int n = 0; n < 8; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(0, 15));
            if (n == 0) begin ra = 8'hFF; rb = 4'hF; end
            exp_m = 12'(ra) * 12'(rb);
            run_mul2(ra, rb, n[0], got, lat);
            checks++; if (lat !== 2) begin fails++; $display("FAIL sweep_latency n=%0d got %0d exp 2", n, lat); end
            checks++; if (got !== exp_m) begin fails++; $display("FAIL sweep_m a=%h b=%h ap=%b got %h exp %h", ra, rb, n[0], got, exp_m); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_exact_max();
        test_truncated();
        test_zero_identity();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
